// File: rtl/em_pkg.sv
// Shared definitions for the wait-state byte memory: FSM states, the default
// out-of-range fetch word and a helper locating a byte lane in a data word.
package em_pkg;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } em_state_t;

    localparam logic [15:0] BAD_FETCH_DEFAULT = 16'hE800;

    // Bit position of the least significant bit of byte lane 'lane'.
    function automatic int lane_lsb(input int lane);
        return lane * 8;
    endfunction

endpackage

// File: rtl/em_wait_mem_if.sv
// Data-port handshake and instruction-fetch signals of the wait-state memory.
interface em_wait_mem_if #(
    parameter int ADDR_W     = 10,
    parameter int DATA_BYTES = 4
);
    logic                    d_req;
    logic                    d_we;
    logic [DATA_BYTES-1:0]   d_be;
    logic [ADDR_W-1:0]       d_addr;
    logic [8*DATA_BYTES-1:0] d_wdata;
    logic                    d_ack;
    logic [8*DATA_BYTES-1:0] d_rdata;
    logic                    d_err;
    logic [ADDR_W-1:0]       f_addr;
    logic [15:0]             f_instr;
    logic                    f_valid;

    modport master (
        output d_req, d_we, d_be, d_addr, d_wdata, f_addr,
        input  d_ack, d_rdata, d_err, f_instr, f_valid
    );

    modport slave (
        input  d_req, d_we, d_be, d_addr, d_wdata, f_addr,
        output d_ack, d_rdata, d_err, f_instr, f_valid
    );
endinterface

// File: rtl/em_fetch_port.sv
// Registered 16-bit fetch read with range check and forwarding of the bytes
// being committed by the data port in the same cycle.
module em_fetch_port
    import em_pkg::*;
#(
    parameter int          MEM_SIZE   = 128,
    parameter int          ADDR_W     = 10,
    parameter int          DATA_BYTES = 4,
    parameter logic [15:0] BAD_FETCH  = BAD_FETCH_DEFAULT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    init_active,
    input  logic [ADDR_W-1:0]       f_addr,
    input  logic [7:0]              mem [MEM_SIZE],
    input  logic                    cm_we,
    input  logic [ADDR_W-1:0]       cm_addr,
    input  logic [DATA_BYTES-1:0]   cm_be,
    input  logic [8*DATA_BYTES-1:0] cm_wdata,
    output logic [15:0]             f_instr,
    output logic                    f_valid
);

    localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam int SUM_W = ADDR_W + 2;

    logic [SUM_W-1:0] lo_sum;
    logic [SUM_W-1:0] hi_sum;
    logic [SUM_W-1:0] lane_sum;
    logic [7:0]       lo_byte;
    logic [7:0]       hi_byte;
    logic             out_of_range;
    logic [15:0]      next_instr;

    // Array bytes first, then any committing lane that hits either half wins.
    always_comb begin
        lo_sum       = SUM_W'(f_addr);
        hi_sum       = lo_sum + SUM_W'(1);
        out_of_range = (hi_sum >= SUM_W'(MEM_SIZE));
        lo_byte      = mem[lo_sum[IDX_W-1:0]];
        hi_byte      = mem[hi_sum[IDX_W-1:0]];
        lane_sum     = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            lane_sum = SUM_W'(cm_addr) + SUM_W'(i);
            if (cm_we && cm_be[i]) begin
                if (lane_sum == lo_sum) lo_byte = cm_wdata[lane_lsb(i) +: 8];
                if (lane_sum == hi_sum) hi_byte = cm_wdata[lane_lsb(i) +: 8];
            end
        end
        next_instr = out_of_range ? BAD_FETCH : {hi_byte, lo_byte};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            f_instr <= BAD_FETCH;
            f_valid <= 1'b0;
        end else begin
            f_instr <= next_instr;
            f_valid <= !init_active;
        end
    end

endmodule

// File: rtl/em_wait_mem.sv
// Little-endian byte RAM with a wait-stated req/ack data port and a registered
// fetch port; zero-fills itself after every reset before accepting traffic.
module em_wait_mem
    import em_pkg::*;
#(
    parameter int          MEM_SIZE    = 128,
    parameter int          ADDR_W      = 10,
    parameter int          DATA_BYTES  = 4,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [15:0] BAD_FETCH   = BAD_FETCH_DEFAULT
) (
    input  logic         clock,
    input  logic         reset,
    em_wait_mem_if.slave bus,
    output logic         busy
);

    localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam int SUM_W = ADDR_W + 2;
    localparam int DW    = 8 * DATA_BYTES;

    em_state_t             state_q;
    em_state_t             state_d;
    logic [3:0]            cnt_q;
    logic [3:0]            cnt_d;
    logic [IDX_W-1:0]      ptr_q;
    logic                  we_q;
    logic [DATA_BYTES-1:0] be_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DW-1:0]         wdata_q;

    logic [7:0]            mem [MEM_SIZE];
    logic [IDX_W-1:0]      lane_idx [DATA_BYTES];
    logic [SUM_W-1:0]      lane_sum;
    logic [DW-1:0]         rd_word;
    logic                  access_err;
    logic                  commit_we;

    // Reads check every lane, writes only the enabled ones; the wide sum
    // keeps addresses near the top of ADDR_W from wrapping into range.
    always_comb begin
        access_err = 1'b0;
        lane_sum   = '0;
        rd_word    = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            lane_sum    = SUM_W'(addr_q) + SUM_W'(i);
            lane_idx[i] = lane_sum[IDX_W-1:0];
            rd_word[lane_lsb(i) +: 8] = mem[lane_sum[IDX_W-1:0]];
            if ((!we_q || be_q[i]) && (lane_sum >= SUM_W'(MEM_SIZE))) begin
                access_err = 1'b1;
            end
        end
    end

    assign commit_we = (state_q == DONE) && we_q && !access_err;
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                if (ptr_q == IDX_W'(MEM_SIZE - 1)) state_d = IDLE;
            end
            IDLE: begin
                if (bus.d_req) begin
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // An asynchronous reset drops straight into INIT, so a pending DONE never
    // gets to commit its write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            ptr_q       <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            bus.d_ack   <= 1'b0;
            bus.d_rdata <= '0;
            bus.d_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus.d_ack <= (state_q == DONE);
            if (state_q == INIT) begin
                ptr_q <= (ptr_q == IDX_W'(MEM_SIZE - 1)) ? '0 : ptr_q + IDX_W'(1);
            end
            if (state_q == IDLE && bus.d_req) begin
                we_q    <= bus.d_we;
                be_q    <= bus.d_be;
                addr_q  <= bus.d_addr;
                wdata_q <= bus.d_wdata;
            end
            if (state_q == DONE) begin
                bus.d_err <= access_err;
                if (!we_q) bus.d_rdata <= access_err ? '0 : rd_word;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (state_q == INIT) begin
            mem[ptr_q] <= 8'h00;
        end else if (commit_we) begin
            for (int i = 0; i < DATA_BYTES; i++) begin
                if (be_q[i]) mem[lane_idx[i]] <= wdata_q[lane_lsb(i) +: 8];
            end
        end
    end

    em_fetch_port #(
        .MEM_SIZE   (MEM_SIZE),
        .ADDR_W     (ADDR_W),
        .DATA_BYTES (DATA_BYTES),
        .BAD_FETCH  (BAD_FETCH)
    ) u_fetch (
        .clock       (clock),
        .reset       (reset),
        .init_active (state_q == INIT),
        .f_addr      (bus.f_addr),
        .mem         (mem),
        .cm_we       (commit_we),
        .cm_addr     (addr_q),
        .cm_be       (be_q),
        .cm_wdata    (wdata_q),
        .f_instr     (bus.f_instr),
        .f_valid     (bus.f_valid)
    );

endmodule

// File: tb/tb_em_wait_mem.sv
// Directed bench for em_wait_mem: init sweep, word/byte-lane accesses, range
// errors, fetch forwarding and reset in the middle of an access.
module tb_em_wait_mem;

    logic clock;
    logic reset;
    logic busy;
    int   errors;
    int   checks;

    em_wait_mem_if #(.ADDR_W(10), .DATA_BYTES(4)) bus ();

    em_wait_mem #(
        .MEM_SIZE    (128),
        .ADDR_W      (10),
        .DATA_BYTES  (4),
        .WAIT_CYCLES (2),
        .BAD_FETCH   (16'hE800)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Issues one access at a negedge and waits (bounded) for its ack.
    // latency counts rising edges after the edge that sampled d_req.
    task automatic applyStimulus(input logic we, input logic [3:0] be,
                                 input logic [9:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] rdata, output logic err,
                                 output logic [15:0] finstr, output int latency);
        int   cycles;
        logic seen;
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_be    = be;
        bus.d_addr  = addr;
        bus.d_wdata = wdata;
        cycles = 0;
        seen   = 1'b0;
        rdata  = '0;
        err    = 1'b0;
        finstr = '0;
        while (!seen && cycles < 20) begin
            @(negedge clock);
            cycles++;
            bus.d_req = 1'b0;
            if (bus.d_ack === 1'b1) begin
                seen   = 1'b1;
                rdata  = bus.d_rdata;
                err    = bus.d_err;
                finstr = bus.f_instr;
            end
        end
        latency = cycles - 1;
        checkOutput("ack_seen", 32'(seen), 32'd1);
        @(negedge clock);
        checkOutput("ack_pulse", 32'(bus.d_ack), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [15:0] fi;
        int          lat;
        int          ack_count;

        errors      = 0;
        checks      = 0;
        reset       = 1'b1;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_be    = '0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.f_addr  = '0;

        repeat (2) @(negedge clock);
        checkOutput("rst_ack",    32'(bus.d_ack),   32'd0);
        checkOutput("rst_rdata",  bus.d_rdata,      32'd0);
        checkOutput("rst_err",    32'(bus.d_err),   32'd0);
        checkOutput("rst_finstr", 32'(bus.f_instr), 32'h0000E800);
        checkOutput("rst_fvalid", 32'(bus.f_valid), 32'd0);
        checkOutput("rst_busy",   32'(busy),        32'd1);

        reset = 1'b0;
        repeat (127) @(negedge clock);
        checkOutput("init_busy_127", 32'(busy), 32'd1);
        @(negedge clock);
        checkOutput("init_busy_128",   32'(busy),        32'd0);
        checkOutput("init_fvalid_128", 32'(bus.f_valid), 32'd0);
        @(negedge clock);
        checkOutput("init_fvalid_129", 32'(bus.f_valid), 32'd1);
        checkOutput("init_finstr0",    32'(bus.f_instr), 32'd0);

        applyStimulus(1'b0, 4'hF, 10'd0, 32'd0, rd, er, fi, lat);
        checkOutput("rd0_data", rd, 32'd0);
        applyStimulus(1'b0, 4'hF, 10'd124, 32'd0, rd, er, fi, lat);
        checkOutput("rd124_data", rd, 32'd0);
        checkOutput("rd124_err",  32'(er), 32'd0);

        applyStimulus(1'b1, 4'hF, 10'd8, 32'hDEADBEEF, rd, er, fi, lat);
        checkOutput("wr8_latency", 32'(lat), 32'd3);
        checkOutput("wr8_err",     32'(er),  32'd0);
        applyStimulus(1'b0, 4'hF, 10'd8, 32'd0, rd, er, fi, lat);
        checkOutput("rd8_data",    rd,       32'hDEADBEEF);
        checkOutput("rd8_err",     32'(er),  32'd0);
        checkOutput("rd8_latency", 32'(lat), 32'd3);

        applyStimulus(1'b1, 4'b0101, 10'd8, 32'h11223344, rd, er, fi, lat);
        applyStimulus(1'b0, 4'hF, 10'd8, 32'd0, rd, er, fi, lat);
        checkOutput("rd8_be_data", rd, 32'hDE22BE44);
        applyStimulus(1'b0, 4'h0, 10'd8, 32'd0, rd, er, fi, lat);
        checkOutput("rd8_be0_data", rd, 32'hDE22BE44);

        applyStimulus(1'b1, 4'hF, 10'd126, 32'hAABBCCDD, rd, er, fi, lat);
        checkOutput("wr126_err", 32'(er), 32'd1);
        applyStimulus(1'b0, 4'hF, 10'd124, 32'd0, rd, er, fi, lat);
        checkOutput("rd124_after_err", rd, 32'd0);
        applyStimulus(1'b0, 4'h1, 10'd125, 32'd0, rd, er, fi, lat);
        checkOutput("rd125_err",  32'(er), 32'd1);
        checkOutput("rd125_data", rd,      32'd0);
        applyStimulus(1'b1, 4'b0011, 10'd126, 32'h99887766, rd, er, fi, lat);
        checkOutput("wr126_lo_err", 32'(er), 32'd0);

        bus.f_addr = 10'd127;
        @(negedge clock);
        checkOutput("fetch127_bad", 32'(bus.f_instr), 32'h0000E800);
        bus.f_addr = 10'd126;
        @(negedge clock);
        checkOutput("fetch126", 32'(bus.f_instr), 32'h00007766);
        bus.f_addr = 10'd1023;
        @(negedge clock);
        checkOutput("fetch1023_bad", 32'(bus.f_instr), 32'h0000E800);

        bus.f_addr = 10'd20;
        @(negedge clock);
        checkOutput("fetch20_pre", 32'(bus.f_instr), 32'd0);
        applyStimulus(1'b1, 4'b0001, 10'd21, 32'h0000005C, rd, er, fi, lat);
        checkOutput("fwd_hi", 32'(fi), 32'h00005C00);
        applyStimulus(1'b1, 4'b0100, 10'd18, 32'h00A10000, rd, er, fi, lat);
        checkOutput("fwd_lo", 32'(fi), 32'h00005CA1);

        applyStimulus(1'b1, 4'hF, 10'd4, 32'h12345678, rd, er, fi, lat);
        applyStimulus(1'b0, 4'hF, 10'd4, 32'd0, rd, er, fi, lat);
        checkOutput("rd4_before_rst", rd, 32'h12345678);

        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_be    = 4'hF;
        bus.d_addr  = 10'd4;
        bus.d_wdata = 32'hCAFEF00D;
        @(negedge clock);
        bus.d_req = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        ack_count = 0;
        for (int i = 0; i < 140; i++) begin
            @(negedge clock);
            if (bus.d_ack === 1'b1) ack_count++;
            if (i == 0) checkOutput("midrst_fvalid", 32'(bus.f_valid), 32'd0);
            if (i == 1) reset = 1'b0;
        end
        checkOutput("midrst_no_ack", 32'(ack_count), 32'd0);
        checkOutput("midrst_busy",   32'(busy),        32'd0);
        checkOutput("midrst_finstr", 32'(bus.f_instr), 32'd0);
        applyStimulus(1'b0, 4'hF, 10'd4, 32'd0, rd, er, fi, lat);
        checkOutput("rd4_after_init", rd, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
